// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control unit: opcodes, ALU
// operation codes, datapath mux selects and the controller state enum.
package rv32_ctrl_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ALU operation codes
    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_SLL   = 4'd2;
    localparam logic [3:0] ALU_SLT   = 4'd3;
    localparam logic [3:0] ALU_SLTU  = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_OR    = 4'd8;
    localparam logic [3:0] ALU_AND   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Immediate format select
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b011;
    localparam logic [2:0] IMM_J = 3'b100;

    // Register-file write-data select
    localparam logic [1:0] RD_ALU = 2'b00;
    localparam logic [1:0] RD_MEM = 2'b01;
    localparam logic [1:0] RD_PC4 = 2'b10;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_TRAP      = 3'd6
    } state_e;

    // Map fun3 to an ALU op for register and immediate arithmetic.
    // alt_bit is instr[30]; it selects SUB only for register ops and SRA
    // for right shifts of either kind.
    function automatic logic [3:0] alu_from_fun3(input logic [2:0] f3,
                                                 input logic alt_bit,
                                                 input logic is_reg);
        logic [3:0] op;
        case (f3)
            3'd0:    op = (is_reg && alt_bit) ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt_bit ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32_alu_decoder.sv
// Combinational instruction-class decoder: opcode/fun3/fun7 bit to ALU
// operation, immediate format and a legality flag.
module rv32_alu_decoder
    import rv32_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] fun3,
    input  logic       fun7b,
    output logic [3:0] alu_control,
    output logic [2:0] imm_sel,
    output logic       legal
);

    // Decode the opcode; unknown opcodes fall to the illegal default
    always_comb begin
        alu_control = ALU_ADD;
        imm_sel     = IMM_I;
        legal       = 1'b1;
        case (opcode)
            OP_R:      alu_control = alu_from_fun3(fun3, fun7b, 1'b1);
            OP_I:      alu_control = alu_from_fun3(fun3, fun7b, 1'b0);
            OP_LOAD:   imm_sel     = IMM_I;
            OP_STORE:  imm_sel     = IMM_S;
            OP_BRANCH: imm_sel     = IMM_B;
            OP_JAL:    imm_sel     = IMM_J;
            OP_JALR:   imm_sel     = IMM_I;
            OP_LUI: begin
                alu_control = ALU_PASSB;
                imm_sel     = IMM_U;
            end
            OP_AUIPC:  imm_sel     = IMM_U;
            default:   legal       = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_controlunit.sv
// Multi-cycle RV32I controller. Walks each instruction through
// FETCH/DECODE/EXECUTE/[MEMORY]/[WRITEBACK], waits on a variable-latency
// memory, traps illegal opcodes and counts retired instructions.
//
// Memory handshake: mem_req is held high while the controller waits in
// FETCH or MEMORY; the transfer completes in the cycle where mem_req and
// mem_ready are both high. If mem_ready stays low until the wait counter
// reaches MEM_TIMEOUT, the next cycle drops mem_req and pulses mem_fault;
// mem_ready is ignored in that cycle because no request is outstanding.
// A mem_ready arriving in the last counted wait cycle completes the
// transfer and the counter never reaches the limit.
module multicycle_controlunit
    import rv32_ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 4,
    parameter int CNT_W       = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           instr,
    input  logic                  branch_taken,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic [1:0]            pc_src,
    output logic                  reg_write,
    output logic [1:0]            rd_sel,
    output logic [2:0]            imm_sel,
    output logic                  operand_a,
    output logic                  operand_b,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic                  mem_fault,
    output logic [CNT_W-1:0]      instret
);

    localparam int              TMO_W      = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(MEM_TIMEOUT);
    localparam logic            TMO_EN     = (MEM_TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    logic [6:0] opcode;
    logic       rd_zero;
    logic       is_r, is_load, is_store, is_branch, is_jal, is_jalr, is_auipc;
    logic       in_mem_wait;
    logic       tmo_expired;
    logic [3:0] dec_alu;
    logic [2:0] dec_imm;
    logic       dec_legal;
    logic       unused_instr_bits;

    assign opcode    = instr[6:0];
    assign rd_zero   = (instr[11:7] == 5'd0);
    assign is_r      = (opcode == OP_R);
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_auipc  = (opcode == OP_AUIPC);

    // Register/immediate fields are consumed by the datapath, not here
    assign unused_instr_bits = ^{instr[31], instr[29:15]};

    assign in_mem_wait = (state_q == ST_FETCH) || (state_q == ST_MEMORY);
    assign tmo_expired = TMO_EN && in_mem_wait && (tmo_q == TMO_LIMIT);
    assign instret     = instret_q;

    rv32_alu_decoder u_alu_decoder (
        .opcode      (opcode),
        .fun3        (instr[14:12]),
        .fun7b       (instr[30]),
        .alu_control (dec_alu),
        .imm_sel     (dec_imm),
        .legal       (dec_legal)
    );

    // State, wait counter and retirement counter registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            tmo_q     <= '0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            instret_q <= instret_d;
        end
    end

    // Next state, wait-counter update and retirement detection
    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        retire  = 1'b0;
        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                if (tmo_expired) begin
                    state_d = ST_FETCH;
                end else if (mem_ready) begin
                    state_d = ST_DECODE;
                end else begin
                    tmo_d = TMO_EN ? tmo_q + 1'b1 : '0;
                end
            end
            ST_DECODE: state_d = dec_legal ? ST_EXECUTE : ST_TRAP;
            ST_EXECUTE: begin
                if (is_branch) begin
                    state_d = ST_FETCH;
                    retire  = 1'b1;
                end else if (is_load || is_store) begin
                    state_d = ST_MEMORY;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_MEMORY: begin
                if (tmo_expired) begin
                    state_d = ST_FETCH;
                end else if (mem_ready) begin
                    state_d = is_store ? ST_FETCH : ST_WRITEBACK;
                    retire  = is_store;
                end else begin
                    tmo_d = TMO_EN ? tmo_q + 1'b1 : '0;
                end
            end
            ST_WRITEBACK: begin
                state_d = ST_FETCH;
                retire  = 1'b1;
            end
            ST_TRAP: state_d = ST_FETCH;
            default: state_d = ST_IDLE;
        endcase
        instret_d = instret_q + CNT_W'(retire);
    end

    // Datapath controls: Moore on state and instr, plus mem_ready/branch_taken
    // only where a completion or a branch outcome gates a write
    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_PLUS4;
        reg_write     = 1'b0;
        rd_sel        = RD_ALU;
        imm_sel       = IMM_I;
        operand_a     = 1'b0;
        operand_b     = 1'b0;
        alu_control   = '0;
        illegal_instr = 1'b0;
        mem_fault     = 1'b0;
        if (state_q == ST_DECODE || state_q == ST_EXECUTE ||
            state_q == ST_MEMORY || state_q == ST_WRITEBACK) begin
            imm_sel     = dec_imm;
            alu_control = ALU_CTRL_W'(dec_alu);
        end
        case (state_q)
            ST_FETCH: begin
                mem_req   = !tmo_expired;
                mem_fault = tmo_expired;
                ir_write  = mem_ready && !tmo_expired;
            end
            ST_EXECUTE: begin
                operand_a = is_auipc || is_jal || is_branch;
                operand_b = !is_r;
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = branch_taken ? PC_TARGET : PC_PLUS4;
                end
            end
            ST_MEMORY: begin
                mem_req   = !tmo_expired;
                mem_we    = is_store && !tmo_expired;
                mem_fault = tmo_expired;
                pc_write  = is_store && mem_ready && !tmo_expired;
            end
            ST_WRITEBACK: begin
                reg_write = !rd_zero;
                pc_write  = 1'b1;
                if (is_load) begin
                    rd_sel = RD_MEM;
                end else if (is_jal || is_jalr) begin
                    rd_sel = RD_PC4;
                end
                if (is_jal) begin
                    pc_src = PC_TARGET;
                end else if (is_jalr) begin
                    pc_src = PC_JALR;
                end
            end
            ST_TRAP: begin
                illegal_instr = 1'b1;
                pc_write      = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_controlunit.sv
// Directed bench for multicycle_controlunit: hand-computed control values
// for each instruction class, memory wait/timeout and mid-instruction reset.
module tb_multicycle_controlunit;
    import rv32_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        branch_taken;
    logic        mem_ready;
    logic        mem_req;
    logic        mem_we;
    logic        ir_write;
    logic        pc_write;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic [1:0]  rd_sel;
    logic [2:0]  imm_sel;
    logic        operand_a;
    logic        operand_b;
    logic [3:0]  alu_control;
    logic        illegal_instr;
    logic        mem_fault;
    logic [31:0] instret;

    int total = 0;
    int bad   = 0;
    int exp_ret = 0;
    int req_cycles;

    multicycle_controlunit #(
        .ALU_CTRL_W  (4),
        .CNT_W       (32),
        .MEM_TIMEOUT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .instr         (instr),
        .branch_taken  (branch_taken),
        .mem_ready     (mem_ready),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .reg_write     (reg_write),
        .rd_sel        (rd_sel),
        .imm_sel       (imm_sel),
        .operand_a     (operand_a),
        .operand_b     (operand_b),
        .alu_control   (alu_control),
        .illegal_instr (illegal_instr),
        .mem_fault     (mem_fault),
        .instret       (instret)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // advance one clock and settle just after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_state(input string tag, input state_e exp);
        check(tag, 32'(dut.state_q), 32'(exp));
    endtask

    // Run a non-memory, non-branch instruction from FETCH back to FETCH
    task automatic run_wb(input string name, input logic [31:0] ins,
                          input logic [3:0] alu, input logic [2:0] imm,
                          input logic opa, input logic opb,
                          input logic [1:0] rsel, input logic [1:0] psrc,
                          input logic rw);
        instr = ins;
        mem_ready = 1'b1;
        #1;
        cyc();
        chk_state({name, "_decode_state"}, ST_DECODE);
        check({name, "_imm_sel"}, 32'(imm_sel), 32'(imm));
        check({name, "_alu_dec"}, 32'(alu_control), 32'(alu));
        cyc();
        chk_state({name, "_exec_state"}, ST_EXECUTE);
        check({name, "_operand_a"}, 32'(operand_a), 32'(opa));
        check({name, "_operand_b"}, 32'(operand_b), 32'(opb));
        check({name, "_alu_exec"}, 32'(alu_control), 32'(alu));
        cyc();
        chk_state({name, "_wb_state"}, ST_WRITEBACK);
        check({name, "_rd_sel"}, 32'(rd_sel), 32'(rsel));
        check({name, "_pc_src"}, 32'(pc_src), 32'(psrc));
        check({name, "_pc_write"}, 32'(pc_write), 32'd1);
        check({name, "_reg_write"}, 32'(reg_write), 32'(rw));
        cyc();
        exp_ret++;
        chk_state({name, "_back_fetch"}, ST_FETCH);
        check({name, "_instret"}, instret, 32'(exp_ret));
    endtask

    // Branch from FETCH back to FETCH
    task automatic run_branch(input string name, input logic taken, input logic [1:0] psrc);
        instr = 32'h00208463;
        mem_ready = 1'b1;
        branch_taken = taken;
        #1;
        cyc();
        check({name, "_imm_sel"}, 32'(imm_sel), 32'(IMM_B));
        cyc();
        chk_state({name, "_exec_state"}, ST_EXECUTE);
        check({name, "_pc_write"}, 32'(pc_write), 32'd1);
        check({name, "_pc_src"}, 32'(pc_src), 32'(psrc));
        check({name, "_reg_write"}, 32'(reg_write), 32'd0);
        check({name, "_operand_a"}, 32'(operand_a), 32'd1);
        cyc();
        exp_ret++;
        chk_state({name, "_back_fetch"}, ST_FETCH);
        check({name, "_reg_write_after"}, 32'(reg_write), 32'd0);
        check({name, "_instret"}, instret, 32'(exp_ret));
        branch_taken = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        instr = 32'h0;
        mem_ready = 1'b0;
        branch_taken = 1'b0;
        repeat (2) cyc();

        // reset state
        chk_state("rst_state", ST_IDLE);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_pc_write", 32'(pc_write), 32'd0);
        check("rst_instret", instret, 32'd0);

        // ADD x3,x1,x2 with memory ready immediately
        rst_n = 1'b1;
        instr = 32'h002081B3;
        mem_ready = 1'b1;
        #1;
        chk_state("add_idle", ST_IDLE);
        check("add_idle_mem_req", 32'(mem_req), 32'd0);
        cyc();
        chk_state("add_fetch", ST_FETCH);
        check("add_fetch_req", 32'(mem_req), 32'd1);
        check("add_fetch_we", 32'(mem_we), 32'd0);
        check("add_ir_write", 32'(ir_write), 32'd1);
        check("add_fetch_pcw", 32'(pc_write), 32'd0);
        cyc();
        chk_state("add_decode", ST_DECODE);
        check("add_imm", 32'(imm_sel), 32'(IMM_I));
        cyc();
        chk_state("add_exec", ST_EXECUTE);
        check("add_alu", 32'(alu_control), 32'(ALU_ADD));
        check("add_opb", 32'(operand_b), 32'd0);
        check("add_exec_pcw", 32'(pc_write), 32'd0);
        cyc();
        chk_state("add_wb", ST_WRITEBACK);
        check("add_reg_write", 32'(reg_write), 32'd1);
        check("add_rd_sel", 32'(rd_sel), 32'(RD_ALU));
        check("add_wb_pcw", 32'(pc_write), 32'd1);
        check("add_wb_instret", instret, 32'd0);
        cyc();
        exp_ret = 1;
        chk_state("add_refetch", ST_FETCH);
        check("add_instret", instret, 32'(exp_ret));

        // LW x5,4(x1) with data memory ready after 3 wait cycles
        instr = 32'h0040A283;
        mem_ready = 1'b1;
        #1;
        cyc();
        check("lw_imm", 32'(imm_sel), 32'(IMM_I));
        cyc();
        chk_state("lw_exec", ST_EXECUTE);
        check("lw_opb", 32'(operand_b), 32'd1);
        check("lw_alu", 32'(alu_control), 32'(ALU_ADD));
        mem_ready = 1'b0;
        cyc();
        req_cycles = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            chk_state("lw_mem_state", ST_MEMORY);
            if (mem_req) req_cycles++;
            check("lw_mem_we", 32'(mem_we), 32'd0);
            check("lw_mem_pcw", 32'(pc_write), 32'd0);
            cyc();
        end
        check("lw_req_cycles", 32'(req_cycles), 32'd4);
        chk_state("lw_wb", ST_WRITEBACK);
        check("lw_rd_sel", 32'(rd_sel), 32'(RD_MEM));
        check("lw_reg_write", 32'(reg_write), 32'd1);
        check("lw_wb_req", 32'(mem_req), 32'd0);
        cyc();
        exp_ret++;
        check("lw_instret", instret, 32'(exp_ret));

        // BEQ taken / not taken
        run_branch("beq_t", 1'b1, PC_TARGET);
        run_branch("beq_nt", 1'b0, PC_PLUS4);

        // ALU decode and writeback variants
        run_wb("sub",   32'h40208133, ALU_SUB,   IMM_I, 1'b0, 1'b0, RD_ALU, PC_PLUS4, 1'b1);
        run_wb("srai",  32'h4030D093, ALU_SRA,   IMM_I, 1'b0, 1'b1, RD_ALU, PC_PLUS4, 1'b1);
        run_wb("lui",   32'h123450B7, ALU_PASSB, IMM_U, 1'b0, 1'b1, RD_ALU, PC_PLUS4, 1'b1);
        run_wb("auipc", 32'h00001197, ALU_ADD,   IMM_U, 1'b1, 1'b1, RD_ALU, PC_PLUS4, 1'b1);
        run_wb("jal",   32'h008000EF, ALU_ADD,   IMM_J, 1'b1, 1'b1, RD_PC4, PC_TARGET, 1'b1);
        run_wb("jalr",  32'h000100E7, ALU_ADD,   IMM_I, 1'b0, 1'b1, RD_PC4, PC_JALR, 1'b1);

        // illegal opcode
        instr = 32'h0000007F;
        mem_ready = 1'b1;
        #1;
        cyc();
        cyc();
        chk_state("ill_trap", ST_TRAP);
        check("ill_pulse", 32'(illegal_instr), 32'd1);
        check("ill_pcw", 32'(pc_write), 32'd1);
        check("ill_pc_src", 32'(pc_src), 32'(PC_PLUS4));
        check("ill_reg_write", 32'(reg_write), 32'd0);
        cyc();
        chk_state("ill_refetch", ST_FETCH);
        check("ill_pulse_end", 32'(illegal_instr), 32'd0);
        check("ill_instret", instret, 32'(exp_ret));

        // fetch timeout with MEM_TIMEOUT=4
        mem_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            check("tmo_wait_req", 32'(mem_req), 32'd1);
            check("tmo_wait_fault", 32'(mem_fault), 32'd0);
            cyc();
        end
        chk_state("tmo_state", ST_FETCH);
        check("tmo_fault", 32'(mem_fault), 32'd1);
        check("tmo_req_drop", 32'(mem_req), 32'd0);
        check("tmo_ir_write", 32'(ir_write), 32'd0);
        cyc();
        check("tmo_reissue", 32'(mem_req), 32'd1);
        check("tmo_fault_end", 32'(mem_fault), 32'd0);

        // SW x2,0(x1) completing normally
        instr = 32'h0020A023;
        mem_ready = 1'b1;
        #1;
        cyc();
        check("sw_imm", 32'(imm_sel), 32'(IMM_S));
        cyc();
        cyc();
        chk_state("sw_mem", ST_MEMORY);
        check("sw_we", 32'(mem_we), 32'd1);
        check("sw_pcw", 32'(pc_write), 32'd1);
        check("sw_pc_src", 32'(pc_src), 32'(PC_PLUS4));
        cyc();
        exp_ret++;
        chk_state("sw_refetch", ST_FETCH);
        check("sw_instret", instret, 32'(exp_ret));

        // SW aborted by reset while in MEMORY
        cyc();
        cyc();
        mem_ready = 1'b0;
        cyc();
        chk_state("swr_mem", ST_MEMORY);
        check("swr_req", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        cyc();
        exp_ret = 0;
        chk_state("swr_idle", ST_IDLE);
        check("swr_req_low", 32'(mem_req), 32'd0);
        check("swr_pcw", 32'(pc_write), 32'd0);
        check("swr_reg_write", 32'(reg_write), 32'd0);
        check("swr_instret", instret, 32'd0);

        // ADDI x0,x0,1 retires without a register write
        rst_n = 1'b1;
        #1;
        cyc();
        chk_state("addi_fetch", ST_FETCH);
        run_wb("addi_x0", 32'h00100013, ALU_ADD, IMM_I, 1'b0, 1'b1, RD_ALU, PC_PLUS4, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
